// File: rtl/stream_arb_2to1_if.sv
// Handshake bundle for the 2:1 stream arbiter: two input channels and one
// registered output channel.
interface stream_arb_2to1_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_ready;

  // Arbiter side
  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_sel
  );

  // Upstream/downstream environment side
  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/stream_arb_2to1.sv
// Registered 2-input stream arbiter: round-robin (or fixed a-first) grant,
// muxed payload into a single output register, saturating per-source
// transfer counters.
module stream_arb_2to1 #(
  parameter int WIDTH      = 8,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_arb_2to1_if.slave s,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t prio_q, prio_d;
  logic  load;
  logic  grant_a, grant_b;
  logic  xfer_a, xfer_b;

  // Output register can accept a word when empty or being drained this cycle.
  assign load = !s.out_valid || s.out_ready;

  // Grant selection from current valids and priority pointer.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (s.a_valid && s.b_valid) begin
      if (FIXED_PRIO || (prio_q == PRIO_A)) grant_a = 1'b1;
      else                                  grant_b = 1'b1;
    end else if (s.a_valid) begin
      grant_a = 1'b1;
    end else if (s.b_valid) begin
      grant_b = 1'b1;
    end
  end

  // Readies are held low while reset is asserted, even though load is high then.
  assign s.a_ready = rst_n & load & grant_a;
  assign s.b_ready = rst_n & load & grant_b;
  assign xfer_a    = s.a_valid & s.a_ready;
  assign xfer_b    = s.b_valid & s.b_ready;

  // Priority pointer next state: hand priority to the other side after any transfer.
  always_comb begin
    prio_d = prio_q;
    if (!FIXED_PRIO) begin
      if (xfer_a)      prio_d = PRIO_B;
      else if (xfer_b) prio_d = PRIO_A;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= PRIO_A;
    else        prio_q <= prio_d;
  end

  // Output register: load the winner, or empty when consumed without a new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.out_sel   <= 1'b0;
    end else if (xfer_a) begin
      s.out_valid <= 1'b1;
      s.out_data  <= s.a_data;
      s.out_sel   <= 1'b0;
    end else if (xfer_b) begin
      s.out_valid <= 1'b1;
      s.out_data  <= s.b_data;
      s.out_sel   <= 1'b1;
    end else if (s.out_ready) begin
      s.out_valid <= 1'b0;
    end
  end

  // Saturating transfer counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (cnt_clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (xfer_a && (cnt_a != '1)) cnt_a <= cnt_a + 1'b1;
      if (xfer_b && (cnt_b != '1)) cnt_b <= cnt_b + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_arb_2to1.sv
// Scoreboard bench for stream_arb_2to1: round-robin instance checked through
// an expected-output queue, plus fixed-priority and narrow-counter instances.
module tb_stream_arb_2to1;

  logic clk;
  logic rst_n;
  logic cnt_clr0, cnt_clr1, cnt_clr2;
  logic [15:0] cnt_a0, cnt_b0, cnt_a1, cnt_b1;
  logic [2:0]  cnt_a2, cnt_b2;

  int compared   = 0;
  int mismatched = 0;

  logic [8:0] exp_q[$];

  stream_arb_2to1_if #(.WIDTH(8)) bus0();
  stream_arb_2to1_if #(.WIDTH(8)) bus1();
  stream_arb_2to1_if #(.WIDTH(8)) bus2();

  stream_arb_2to1 #(.WIDTH(8), .FIXED_PRIO(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .s(bus0), .cnt_clr(cnt_clr0), .cnt_a(cnt_a0), .cnt_b(cnt_b0)
  );
  stream_arb_2to1 #(.WIDTH(8), .FIXED_PRIO(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .s(bus1), .cnt_clr(cnt_clr1), .cnt_a(cnt_a1), .cnt_b(cnt_b1)
  );
  stream_arb_2to1 #(.WIDTH(8), .FIXED_PRIO(1'b0), .CNT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .s(bus2), .cnt_clr(cnt_clr2), .cnt_a(cnt_a2), .cnt_b(cnt_b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output word of dut0 is matched against the queue.
  always @(negedge clk) begin
    if (rst_n && bus0.out_valid && bus0.out_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL out_word: got sel=%0d data=%h expected nothing (queue empty)",
                 bus0.out_sel, bus0.out_data);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({bus0.out_sel, bus0.out_data} !== e) begin
          mismatched++;
          $display("FAIL out_word: got sel=%0d data=%h expected sel=%0d data=%h",
                   bus0.out_sel, bus0.out_data, e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cnt_clr0 = 1'b0; cnt_clr1 = 1'b0; cnt_clr2 = 1'b0;
    bus0.a_valid = 1'b0; bus0.a_data = '0; bus0.b_valid = 1'b0; bus0.b_data = '0; bus0.out_ready = 1'b0;
    bus1.a_valid = 1'b0; bus1.a_data = '0; bus1.b_valid = 1'b0; bus1.b_data = '0; bus1.out_ready = 1'b0;
    bus2.a_valid = 1'b0; bus2.a_data = '0; bus2.b_valid = 1'b0; bus2.b_data = '0; bus2.out_ready = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Preload a word and hold it under backpressure, then reset mid-stream.
    bus0.a_valid = 1'b1; bus0.a_data = 8'h77; bus0.out_ready = 1'b0;
    cyc();
    bus0.a_valid = 1'b0;
    chk("pre_valid", bus0.out_valid, 1);
    chk("pre_cnt_a", cnt_a0, 1);
    cyc();
    chk("pre_hold", bus0.out_data, 8'h77);
    rst_n = 1'b0;
    bus0.a_valid = 1'b1;
    #1;
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_out_data", bus0.out_data, 0);
    chk("rst_out_sel", bus0.out_sel, 0);
    chk("rst_cnt_a", cnt_a0, 0);
    chk("rst_cnt_b", cnt_b0, 0);
    chk("rst_a_ready", bus0.a_ready, 0);
    bus0.a_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();

    // Basic path.
    bus0.a_valid = 1'b1; bus0.a_data = 8'h3C; bus0.out_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h3C});
    cyc();
    bus0.a_valid = 1'b0;
    chk("basic_valid", bus0.out_valid, 1);
    chk("basic_data", bus0.out_data, 8'h3C);
    chk("basic_cnt_a", cnt_a0, 1);

    // One b word returns priority to a; clear wins over its increment.
    bus0.b_valid = 1'b1; bus0.b_data = 8'h5B; cnt_clr0 = 1'b1;
    exp_q.push_back({1'b1, 8'h5B});
    cyc();
    bus0.b_valid = 1'b0; cnt_clr0 = 1'b0;
    chk("clr_cnt_a", cnt_a0, 0);
    chk("clr_cnt_b", cnt_b0, 0);

    // Round-robin contention: AA,55 alternating, no bubbles.
    bus0.a_valid = 1'b1; bus0.a_data = 8'hAA;
    bus0.b_valid = 1'b1; bus0.b_data = 8'h55;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) exp_q.push_back({1'b0, 8'hAA});
      else            exp_q.push_back({1'b1, 8'h55});
      #1;
      chk("rr_a_ready", bus0.a_ready, (i % 2 == 0) ? 1 : 0);
      cyc();
    end
    chk("rr_cnt_a", cnt_a0, 4);
    chk("rr_cnt_b", cnt_b0, 4);

    // Backpressure: hold 11 for 3 cycles with both valid.
    bus0.b_valid = 1'b0; bus0.a_data = 8'h11;
    exp_q.push_back({1'b0, 8'h11});
    cyc();
    bus0.out_ready = 1'b0;
    bus0.a_valid = 1'b1; bus0.a_data = 8'h22;
    bus0.b_valid = 1'b1; bus0.b_data = 8'h33;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_a_ready", bus0.a_ready, 0);
      chk("bp_b_ready", bus0.b_ready, 0);
      cyc();
      chk("bp_hold_data", bus0.out_data, 8'h11);
      chk("bp_hold_valid", bus0.out_valid, 1);
    end
    bus0.out_ready = 1'b1;
    exp_q.push_back({1'b1, 8'h33});
    #1;
    chk("bp_release_b_ready", bus0.b_ready, 1);
    chk("bp_release_a_ready", bus0.a_ready, 0);
    cyc();

    // Drain, then confirm idle cycles left priority on a.
    bus0.a_valid = 1'b0; bus0.b_valid = 1'b0;
    cyc();
    chk("drain_valid", bus0.out_valid, 0);
    cyc();
    bus0.a_valid = 1'b1; bus0.a_data = 8'h44;
    bus0.b_valid = 1'b1; bus0.b_data = 8'h66;
    exp_q.push_back({1'b0, 8'h44});
    cyc();
    bus0.a_valid = 1'b0; bus0.b_valid = 1'b0;
    cyc();
    chk("drain2_valid", bus0.out_valid, 0);

    // Fixed priority instance.
    bus1.out_ready = 1'b1;
    bus1.a_valid = 1'b1; bus1.a_data = 8'hA1;
    bus1.b_valid = 1'b1; bus1.b_data = 8'hB1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("fp_a_ready", bus1.a_ready, 1);
      chk("fp_b_ready", bus1.b_ready, 0);
      cyc();
    end
    chk("fp_cnt_a", cnt_a1, 5);
    chk("fp_cnt_b", cnt_b1, 0);
    chk("fp_data", bus1.out_data, 8'hA1);
    bus1.a_valid = 1'b0;
    #1;
    chk("fp_b_ready_after_drop", bus1.b_ready, 1);
    cyc();
    bus1.b_valid = 1'b0;
    chk("fp_b_sel", bus1.out_sel, 1);
    chk("fp_b_data", bus1.out_data, 8'hB1);
    chk("fp_b_cnt", cnt_b1, 1);

    // Narrow counter saturation and clear.
    bus2.out_ready = 1'b1;
    bus2.a_valid = 1'b1; bus2.a_data = 8'h01;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      chk("sat_cnt_a", cnt_a2, (i > 7) ? 7 : i);
    end
    cnt_clr2 = 1'b1;
    cyc();
    cnt_clr2 = 1'b0;
    chk("sat_clr_cnt_a", cnt_a2, 0);
    cyc();
    chk("sat_after_clr", cnt_a2, 1);
    bus2.a_valid = 1'b0;

    repeat (3) cyc();
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
